// File: rtl/case_state_sequencer.sv
// case_state_sequencer: N-state phase sequencer advanced by step strobe or dwell timer
module case_state_sequencer #(
  parameter int NUM_STATES = 4,
  parameter int OUT_W = 2,
  parameter int NUM_W = 3,
  parameter int DWELL_W = 4,
  parameter int WRAP = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          step,
  input  logic                          hold,
  input  logic                          mode,
  input  logic [DWELL_W-1:0]            dwell_len,
  output logic [OUT_W-1:0]              out,
  output logic [NUM_W-1:0]              out_num,
  output logic [$clog2(NUM_STATES)-1:0] state_o,
  output logic                          at_end,
  output logic                          wrap_pulse
);
  localparam int SW = $clog2(NUM_STATES);
  localparam logic [SW-1:0] STATE_FIRST = '0;
  localparam logic [SW-1:0] STATE_LAST = SW'(NUM_STATES - 1);
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_nxt;
  logic [SW-1:0] state_nxt;
  logic adv;
  logic wrap;
  logic valid;
  always_comb begin
    valid = int'(state_o) < NUM_STATES;
    at_end = state_o == STATE_LAST;
    adv = !hold && (mode ? dwell_cnt >= dwell_len : step);
    wrap = adv && at_end && WRAP != 0;
    state_nxt = !adv ? state_o : at_end ? (WRAP != 0 ? STATE_FIRST : state_o) : state_o + 1'b1;
    // saturating count so a long dwell_len can never be skipped by wraparound
    dwell_nxt = (!mode || adv) ? '0 : (hold || &dwell_cnt) ? dwell_cnt : dwell_cnt + 1'b1;
    out = valid ? OUT_W'(2 * int'(state_o) + 1) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_o <= STATE_FIRST;
      dwell_cnt <= '0;
      out_num <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      state_o <= state_nxt;
      dwell_cnt <= dwell_nxt;
      out_num <= valid ? NUM_W'(2 * int'(state_o) + 2) : '0;
      wrap_pulse <= wrap;
    end
  end
endmodule
